// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu memory port.
// Arbiter states, request bundle and default bus widths.
package tinyalu_pkg;

  localparam int MEM_DW = 16;
  localparam int MEM_AW = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester and memory bus bundle for mem_req_arbiter.
// slave = arbiter view, master = requesters plus memory model.
interface mem_req_arbiter_if #(
  parameter int NCH = 2,
  parameter int DW  = 16,
  parameter int AW  = 14
);

  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    req_we;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH-1:0]    rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [NCH-1:0]    rsp_err;

  logic              cs;
  logic              read_req;
  logic              write_req;
  logic [AW-1:0]     addrout;
  logic [DW-1:0]     datatomem;
  logic [DW-1:0]     datafrommem;
  logic              mem_resp;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output cs, read_req, write_req, addrout, datatomem,
    input  datafrommem, mem_resp
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  cs, read_req, write_req, addrout, datatomem,
    output datafrommem, mem_resp
  );

endinterface

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping at N. Returns one-hot grant and its index.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  always_comb begin
    logic          hit;
    int            c;
    logic [IW-1:0] ci;
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      ci = IW'(c);
      if (!hit && req[ci]) begin
        hit     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin NCH-channel front end for a single-ported memory bus.
// Define MEM_REQ_TIMEOUT_EN to build the response watchdog.
module mem_req_arbiter
  import tinyalu_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DW      = MEM_DW,
  parameter int AW      = MEM_AW,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_req_arbiter_if.slave   bus,
  output logic               busy
);

  localparam int IW = $clog2(NCH);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  arb_state_t     state;
  arb_state_t     nstate;
  req_t           req_q;
  req_t           sel;
  logic [IW-1:0]  gidx_q;
  logic [IW-1:0]  ptr_q;
  logic [IW-1:0]  nxt_ptr;
  logic [DW-1:0]  rdata_q;
  logic [NCH-1:0] gnt;
  logic [IW-1:0]  idx;
  logic [NCH-1:0] own;
  logic           take;
  logic           done;
  logic           expire;
  logic           acc;
  logic           resp;

  rr_arbiter #(.N(NCH)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx)
  );

  assign acc  = (state == ACCESS);
  assign resp = (state == RESP);
  assign take = (state == IDLE) && (|gnt);
  assign done = acc && bus.mem_resp;

  assign sel.we    = bus.req_we[idx];
  assign sel.addr  = bus.req_addr[idx*AW +: AW];
  assign sel.wdata = bus.req_wdata[idx*DW +: DW];

  assign nxt_ptr = (idx == IW'(NCH-1)) ? '0 : idx + IW'(1);
  assign own     = NCH'(1) << gidx_q;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);

  logic [CW-1:0] tcnt;
  logic          err_q;

  // mem_resp in the last allowed cycle beats the abort
  assign expire = acc && !bus.mem_resp
               && (tcnt == CW'(TIMEOUT-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else if (take) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else if (acc && !bus.mem_resp) begin
      tcnt <= tcnt + CW'(1);
      if (expire) err_q <= 1'b1;
    end
  end

  assign bus.rsp_err = (resp && err_q) ? own : '0;
`else
  assign expire      = 1'b0;
  assign bus.rsp_err = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (take) nstate = ACCESS;
      ACCESS:  if (done || expire) nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (take) begin
        req_q  <= sel;
        gidx_q <= idx;
        ptr_q  <= nxt_ptr;
      end
      if (done)        rdata_q <= req_q.we ? '0 : bus.datafrommem;
      else if (expire) rdata_q <= '0;
    end
  end

  assign bus.req_ready = (state == IDLE) ? gnt : '0;
  assign bus.cs        = acc;
  assign bus.read_req  = acc && !req_q.we;
  assign bus.write_req = acc && req_q.we;
  assign bus.addrout   = req_q.addr;
  assign bus.datatomem = req_q.wdata;
  assign bus.rsp_valid = resp ? own : '0;
  assign bus.rsp_rdata = resp ? rdata_q : '0;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter, NCH=4, TIMEOUT=8.
// Watchdog vectors run only when MEM_REQ_TIMEOUT_EN is defined.
module tb_mem_req_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int AW  = 14;

  logic clk;
  logic reset_n;
  logic busy;
  int   checks;
  int   errors;

  mem_req_arbiter_if #(.NCH(NCH), .DW(DW), .AW(AW)) bus ();

  mem_req_arbiter #(
    .NCH(NCH), .DW(DW), .AW(AW), .TIMEOUT(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.req_valid   = '0;
    bus.req_we      = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.datafrommem = '0;
    bus.mem_resp    = 1'b0;
    tick();
    tick();

    check("rst_cs", 32'(bus.cs), 0);
    check("rst_strobes", 32'({bus.read_req, bus.write_req}), 0);
    check("rst_addr", 32'(bus.addrout), 0);
    check("rst_wdata", 32'(bus.datatomem), 0);
    check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err}), 0);
    check("rst_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    tick();

    // single read, ch0, two ACCESS cycles
    bus.req_valid = 4'b0001;
    bus.req_we    = 4'b0000;
    bus.req_addr[0*AW +: AW] = 14'h0123;
    #1;
    check("rd_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    check("rd_cs1", 32'(bus.cs), 1);
    check("rd_rreq1", 32'({bus.read_req, bus.write_req}), 32'h2);
    check("rd_addr1", 32'(bus.addrout), 32'h0123);
    check("rd_busy", 32'(busy), 1);
    tick();
    check("rd_rreq2", 32'(bus.read_req), 1);
    check("rd_addr2", 32'(bus.addrout), 32'h0123);
    bus.mem_resp    = 1'b1;
    bus.datafrommem = 16'hBEEF;
    tick();
    bus.mem_resp = 1'b0;
    check("rd_rsp", 32'(bus.rsp_valid), 32'h1);
    check("rd_data", 32'(bus.rsp_rdata), 32'hBEEF);
    check("rd_cs_off", 32'({bus.cs, bus.read_req}), 0);
    tick();
    check("rd_rsp_end", 32'(bus.rsp_valid), 0);
    check("rd_idle", 32'(busy), 0);

    // single write, ch1, answered in first ACCESS cycle
    bus.req_valid = 4'b0010;
    bus.req_we    = 4'b0010;
    bus.req_addr[1*AW +: AW]  = 14'h3FFF;
    bus.req_wdata[1*DW +: DW] = 16'hA5A5;
    #1;
    check("wr_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    check("wr_wreq", 32'({bus.read_req, bus.write_req}), 32'h1);
    check("wr_addr", 32'(bus.addrout), 32'h3FFF);
    check("wr_data", 32'(bus.datatomem), 32'hA5A5);
    bus.mem_resp    = 1'b1;
    bus.datafrommem = 16'h1111;
    tick();
    bus.mem_resp = 1'b0;
    check("wr_rsp", 32'(bus.rsp_valid), 32'h2);
    check("wr_rdata", 32'(bus.rsp_rdata), 0);
    tick();
    check("wr_idle", 32'(busy), 0);

    // stray mem_resp while idle
    bus.mem_resp    = 1'b1;
    bus.datafrommem = 16'h1234;
    tick();
    bus.mem_resp = 1'b0;
    check("stray_busy", 32'(busy), 0);
    check("stray_rsp", 32'(bus.rsp_valid), 0);
    check("stray_cs", 32'(bus.cs), 0);

    // reset during a read on ch2
    bus.req_valid = 4'b0100;
    bus.req_we    = '0;
    bus.req_addr[2*AW +: AW] = 14'h0042;
    #1;
    check("rr_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    check("rr_cs", 32'(bus.cs), 1);
    reset_n = 1'b0;
    #1;
    check("rr_drop", 32'({bus.cs, bus.read_req, bus.write_req}), 0);
    check("rr_busy", 32'(busy), 0);
    #1;
    reset_n = 1'b1;
    tick();
    check("rr_norsp", 32'(bus.rsp_valid), 0);
    check("rr_idle", 32'(busy), 0);

    // fairness: all channels hold req_valid; pointer restarts at ch0
    bus.req_valid = 4'hF;
    bus.req_we    = '0;
    for (int c = 0; c < NCH; c++)
      bus.req_addr[c*AW +: AW] = 14'(14'h100 + c);
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr%0d_ready", i),
            32'(bus.req_ready), 32'(1 << (i % 4)));
      tick();
      check($sformatf("rr%0d_addr", i),
            32'(bus.addrout), 32'(14'h100 + (i % 4)));
      check($sformatf("rr%0d_hold", i), 32'(bus.req_ready), 0);
      bus.mem_resp    = 1'b1;
      bus.datafrommem = 16'(16'h0A00 + i);
      tick();
      bus.mem_resp = 1'b0;
      check($sformatf("rr%0d_rsp", i),
            32'(bus.rsp_valid), 32'(1 << (i % 4)));
      check($sformatf("rr%0d_data", i),
            32'(bus.rsp_rdata), 32'(16'h0A00 + i));
      tick();
    end
    bus.req_valid = '0;
    tick();

`ifdef MEM_REQ_TIMEOUT_EN
    // no answer: 8 ACCESS cycles then an error response
    bus.req_valid = 4'b0010;
    #1;
    tick();
    bus.req_valid = '0;
    for (int i = 1; i <= 8; i++)
      begin
        check($sformatf("wd_cs%0d", i), 32'(bus.cs), 1);
        tick();
      end
    check("wd_drop", 32'({bus.cs, bus.read_req}), 0);
    check("wd_rsp", 32'(bus.rsp_valid), 32'h2);
    check("wd_err", 32'(bus.rsp_err), 32'h2);
    check("wd_rdata", 32'(bus.rsp_rdata), 0);
    tick();
    check("wd_idle", 32'(busy), 0);

    // answer arrives in the 8th ACCESS cycle
    bus.req_valid = 4'b0100;
    #1;
    tick();
    bus.req_valid = '0;
    for (int i = 1; i < 8; i++) tick();
    check("wd8_cs", 32'(bus.cs), 1);
    bus.mem_resp    = 1'b1;
    bus.datafrommem = 16'h5A5A;
    tick();
    bus.mem_resp = 1'b0;
    check("wd8_rsp", 32'(bus.rsp_valid), 32'h4);
    check("wd8_err", 32'(bus.rsp_err), 0);
    check("wd8_rdata", 32'(bus.rsp_rdata), 32'h5A5A);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
